// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or shift-subtract step per cycle on operand magnitudes, followed by a sign-fix cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W   = 32;
    localparam int unsigned AW  = 2 * W;
    localparam int unsigned CW  = 5;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            signed_in;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [W:0]      sum;
    logic [W:0]      rem_sh;
    logic            ge;
    logic [AW-1:0]   prod_fix;

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        dvd_d     = dvd_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        signed_in = 1'b0;
        mag_a     = '0;
        mag_b     = '0;
        sum       = '0;
        rem_sh    = '0;
        ge        = 1'b0;
        prod_fix  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wdata;
                    else          lo_d = hilo_wdata;
                end
                if (start) begin
                    signed_in = ~op[0];
                    mag_a     = (signed_in && a[W-1]) ? -a : a;
                    mag_b     = (signed_in && b[W-1]) ? -b : b;
                    op_d      = op;
                    sign_a_d  = signed_in & a[W-1];
                    sign_b_d  = signed_in & b[W-1];
                    dvd_d     = a;
                    // mult: opnd = |a| is the addend, |b| shifts out of acc; div: |a| shifts out, opnd = |b|
                    opnd_d    = op[1] ? mag_b : mag_a;
                    acc_d     = op[1] ? {W'(0), mag_a} : {W'(0), mag_b};
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    rem_sh = {acc_q[AW-1:W], acc_q[W-1]};
                    ge     = (rem_sh >= {1'b0, opnd_q});
                    acc_d  = {(ge ? W'(rem_sh - {1'b0, opnd_q}) : rem_sh[W-1:0]),
                              acc_q[W-2:0], ge};
                end else begin
                    sum   = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
                    acc_d = {sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    if (opnd_q == '0) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
                        hi_d = sign_a_q ? -acc_q[AW-1:W] : acc_q[AW-1:W];
                    end
                end else begin
                    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                    hi_d     = prod_fix[AW-1:W];
                    lo_d     = prod_fix[W-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dvd_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dvd_q    <= dvd_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
